// File: rtl/ps2_keyboard_if.sv
// ps2_keyboard_if: keyboard-to-cpu port bundle.
//   kb_tr  - cpu acknowledge; a rising edge pops the FIFO head
//   kb_ch  - FIFO head byte, 8'h00 when empty
//   kb_hit - FIFO not empty
//   kb_ovf - sticky overflow flag
//   kb_err - one-cycle pulse on framing/parity/timeout error
// Modports: master = keyboard receiver side, slave = cpu side.
interface ps2_keyboard_if;
  logic       kb_tr;
  logic [7:0] kb_ch;
  logic       kb_hit;
  logic       kb_ovf;
  logic       kb_err;

  modport master (input kb_tr, output kb_ch, output kb_hit, output kb_ovf, output kb_err);
  modport slave  (output kb_tr, input kb_ch, input kb_hit, input kb_ovf, input kb_err);
endinterface

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 device-to-host receiver with a scan-code FIFO feeding the cpu port.
// Ports:
//   clock   - system clock, rising edge
//   locked  - asynchronous active-low reset
//   ps2_clk - PS/2 clock from the device (asynchronous)
//   ps2_dat - PS/2 data from the device (asynchronous)
//   kb      - ps2_keyboard_if.master (kb_tr in; kb_ch, kb_hit, kb_ovf, kb_err out)
// Build option: define PS2_PARITY_EN to reject frames with a bad (even) parity bit.
// Without it the parity bit is captured but ignored; the stop bit is always checked.
module ps2_keyboard #(
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 25000
) (
  input  logic           clock,
  input  logic           locked,
  input  logic           ps2_clk,
  input  logic           ps2_dat,
  ps2_keyboard_if.master kb
);

  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT + 1);
  localparam logic [FCW-1:0] FltLast = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TmoLast = TCW'(TIMEOUT);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;
  localparam logic [1:0] StStop   = 2'd3;

  // Input synchronisers and clock glitch filter
  logic [1:0]     clk_sync_q, dat_sync_q;
  logic           clk_s, dat_s;
  logic           flt_q, flt_d;
  logic [FCW-1:0] flt_cnt_q, flt_cnt_d;
  logic           fall;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // A level change is accepted on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    flt_d     = flt_q;
    flt_cnt_d = '0;
    if (clk_s != flt_q) begin
      if (flt_cnt_q == FltLast) flt_d = clk_s;
      else                      flt_cnt_d = flt_cnt_q + FCW'(1);
    end
  end

  assign fall = flt_q & ~flt_d;

  // Frame FSM
  logic [1:0]     state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     sh_q, sh_d;
  logic           par_q, par_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           err_q, err_d;
  logic           push;
  logic           parity_good, par_ok;

  assign parity_good = ^{sh_q, par_q};
`ifdef PS2_PARITY_EN
  assign par_ok = parity_good;
`else
  logic unused_parity;
  assign unused_parity = parity_good;
  assign par_ok        = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    par_d    = par_q;
    err_d    = 1'b0;
    push     = 1'b0;
    tmo_d    = (state_q == StIdle) ? '0 : tmo_q + TCW'(1);
    if (fall) begin
      tmo_d = '0;
      case (state_q)
        StIdle: begin
          if (!dat_s) begin
            state_d  = StData;
            bitcnt_d = 3'd0;
          end
        end
        StData: begin
          sh_d     = {dat_s, sh_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = dat_s;
          state_d = StStop;
        end
        default: begin
          state_d = StIdle;
          if (dat_s && par_ok) push  = 1'b1;
          else                 err_d = 1'b1;
        end
      endcase
    end else if (state_q != StIdle && tmo_q == TmoLast) begin
      // Device stalled mid-frame: abandon it.
      state_d = StIdle;
      err_d   = 1'b1;
      tmo_d   = '0;
    end
  end

  // FIFO
  logic [7:0]       mem_q [2**FIFO_AW];
  logic [FIFO_AW:0] wp_q, rp_q;
  logic             kb_tr_q, ovf_q;
  logic             empty, full, do_pop, do_push, last_one;

  assign empty    = (wp_q == rp_q);
  assign full     = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) &&
                    (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
  assign do_pop   = kb.kb_tr & ~kb_tr_q & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push  = push & (~full | do_pop);
  assign last_one = ((rp_q + (FIFO_AW+1)'(1)) == wp_q);

  always_ff @(posedge clock or negedge locked) begin
    if (!locked) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      flt_q      <= 1'b1;
      flt_cnt_q  <= '0;
      state_q    <= StIdle;
      bitcnt_q   <= 3'd0;
      sh_q       <= 8'h00;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
      kb_tr_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
      flt_q      <= flt_d;
      flt_cnt_q  <= flt_cnt_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      sh_q       <= sh_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      kb_tr_q    <= kb.kb_tr;
      if (do_push) wp_q <= wp_q + (FIFO_AW+1)'(1);
      if (do_pop)  rp_q <= rp_q + (FIFO_AW+1)'(1);
      if (push && full && !do_pop)            ovf_q <= 1'b1;
      else if (do_pop && !do_push && last_one) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wp_q[FIFO_AW-1:0]] <= sh_q;
  end

  assign kb.kb_ch  = empty ? 8'h00 : mem_q[rp_q[FIFO_AW-1:0]];
  assign kb.kb_hit = ~empty;
  assign kb.kb_ovf = ovf_q;
  assign kb.kb_err = err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: randomized frames and pops against a queue-based reference model.
module tb_ps2_keyboard;

  localparam int TIMEOUT = 25000;
  localparam int HP      = 12;   // PS/2 half period in system clocks
  localparam int DEPTH   = 16;

  logic clock = 1'b0;
  logic locked;
  logic ps2_clk, ps2_dat;

  ps2_keyboard_if kb_bus ();

  ps2_keyboard #(
    .FIFO_AW   (4),
    .FILTER_LEN(8),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clock  (clock),
    .locked (locked),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .kb     (kb_bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model
  logic [7:0] exp_q[$];
  bit         exp_ovf = 0;
  int         exp_err = 0;

  // Error pulse monitor
  int err_cnt  = 0;
  int err_long = 0;
  bit err_prev = 0;
  always @(negedge clock) begin
    if (kb_bus.kb_err === 1'b1) begin
      err_cnt++;
      if (err_prev) err_long++;
    end
    err_prev = (kb_bus.kb_err === 1'b1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".hit"}, 32'(kb_bus.kb_hit), 32'(exp_q.size() != 0));
    check_eq({tag, ".ch"}, 32'(kb_bus.kb_ch), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
    check_eq({tag, ".ovf"}, 32'(kb_bus.kb_ovf), 32'(exp_ovf));
    check_eq({tag, ".err"}, 32'(err_cnt), 32'(exp_err));
  endtask

  function automatic void model_frame(input logic [7:0] d, input bit bad_par,
                                      input bit bad_stop);
    bit accept;
    accept = !bad_stop;
`ifdef PS2_PARITY_EN
    accept = accept && !bad_par;
`else
    if (bad_par) accept = accept;
`endif
    if (!accept)                  exp_err++;
    else if (exp_q.size() == DEPTH) exp_ovf = 1;
    else                          exp_q.push_back(d);
  endfunction

  function automatic void model_pop();
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) exp_ovf = 0;
    end
  endfunction

  // Sends the first nbits of an 11-bit frame; data changes while ps2_clk is high.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock) ps2_dat = f[i];
      repeat (HP) @(negedge clock);
      ps2_clk = 1'b0;
      repeat (HP) @(negedge clock);
      ps2_clk = 1'b1;
    end
    repeat (HP) @(negedge clock);
    ps2_dat = 1'b1;
  endtask

  task automatic good_frame(input logic [7:0] d);
    model_frame(d, 0, 0);
    send_frame(d, 0, 0, 11);
  endtask

  task automatic pop_pulse(input int hold);
    @(negedge clock) kb_bus.kb_tr = 1'b1;
    repeat (hold) @(negedge clock);
    kb_bus.kb_tr = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    logic [7:0] d;
    bit bp, bs, dp;
    int dly, hold;

    locked       = 1'b0;
    ps2_clk      = 1'b1;
    ps2_dat      = 1'b1;
    kb_bus.kb_tr = 1'b0;
    repeat (4) @(negedge clock);
    check_eq("rst.hit", 32'(kb_bus.kb_hit), 32'h0);
    check_eq("rst.ch", 32'(kb_bus.kb_ch), 32'h0);
    check_eq("rst.ovf", 32'(kb_bus.kb_ovf), 32'h0);
    check_eq("rst.err", 32'(kb_bus.kb_err), 32'h0);
    locked = 1'b1;
    repeat (4) @(negedge clock);

    // Basic frame and pop
    good_frame(8'h1C);
    check_state("t1.frame");
    model_pop();
    pop_pulse(1);
    check_state("t1.pop");

    // Parity bit wrong
    model_frame(8'h1C, 1, 0);
    send_frame(8'h1C, 1, 0, 11);
    check_state("t2");
    model_pop();
    pop_pulse(1);

    // Overflow on the 17th frame, then drain in order
    for (int i = 1; i <= 17; i++) good_frame(8'(i));
    check_state("t3.full");
    for (int i = 0; i < 16; i++) begin
      model_pop();
      pop_pulse(1 + (i % 3));
      check_state("t3.drain");
    end

    // Partial frame then timeout
    exp_err++;
    send_frame(8'h00, 0, 0, 5);
    repeat (TIMEOUT + 50) @(negedge clock);
    check_state("t4.tmo");
    good_frame(8'hF0);
    check_state("t4.next");
    model_pop();
    pop_pulse(1);

    // Short low glitch on ps2_clk must be filtered out
    @(negedge clock) ps2_clk = 1'b0;
    repeat (3) @(negedge clock);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clock);
    good_frame(8'h5A);
    check_state("t5");
    model_pop();
    pop_pulse(1);

    // Reset mid-frame with an overflowed, partly drained FIFO
    for (int i = 0; i < 17; i++) good_frame(8'($urandom));
    for (int i = 0; i < 14; i++) begin
      model_pop();
      pop_pulse(1);
    end
    check_state("t6.pre");
    send_frame(8'hA5, 0, 0, 5);
    @(negedge clock) locked = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 0;
    check_state("t6.rst");
    repeat (3) @(negedge clock);
    locked = 1'b1;
    repeat (3) @(negedge clock);
    good_frame(8'h5A);
    check_state("t6.after");

    // Randomized frames with interleaved pops early in each frame
    for (int n = 0; n < 40; n++) begin
      d    = 8'($urandom);
      bp   = ($urandom_range(0, 3) == 0);
      bs   = ($urandom_range(0, 7) == 0);
      dp   = ($urandom_range(0, 3) == 0);
      dly  = $urandom_range(1, 40);
      hold = $urandom_range(1, 4);
      if (dp) model_pop();
      model_frame(d, bp, bs);
      fork
        send_frame(d, bp, bs, 11);
        begin
          if (dp) begin
            repeat (dly) @(negedge clock);
            pop_pulse(hold);
          end
        end
      join
      check_state("rnd");
    end
    while (exp_q.size() != 0) begin
      model_pop();
      pop_pulse($urandom_range(1, 4));
      check_state("rnd.drain");
    end
    check_eq("err.width", 32'(err_long), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
